// File: rtl/snn_pkg.sv
// Shared types, widths and helpers for spiking-neuron blocks.
package snn_pkg;

    localparam int unsigned VW   = 12;    // membrane potential width
    localparam int unsigned IW   = 11;    // input current width
    localparam int unsigned VMAX = 4095;  // membrane saturation value
    localparam int unsigned NPRE = 5;     // pre-synaptic lines per neuron
    localparam int unsigned WW   = 8;     // synaptic weight width
    localparam int unsigned PCW  = 3;     // popcount width for NPRE lines
    localparam int unsigned CW   = 8;     // spike counter width
    localparam int unsigned RW   = 8;     // refractory counter width

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } neuron_state_e;

    // Number of active pre-synaptic lines.
    function automatic logic [PCW-1:0] popcount_pre(input logic [NPRE-1:0] lines);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NPRE); i++) begin
            cnt = cnt + PCW'(lines[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/snn_input_sum.sv
// Combinational synaptic input current: popcount(pre_spike) * weight.
module snn_input_sum
    import snn_pkg::*;
(
    input  logic [NPRE-1:0] pre_spike_i,
    input  logic [WW-1:0]   weight_i,
    output logic [IW-1:0]   current_c
);

    logic [PCW-1:0] active_cnt;

    // Product of at most 5 * 255 = 1275 always fits in IW bits.
    always_comb begin
        active_cnt = popcount_pre(pre_spike_i);
        current_c  = IW'(active_cnt) * IW'(weight_i);
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with shift leak, saturation and refractory period.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int unsigned THRESHOLD      = 1000,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NPRE-1:0] pre_spike,
    input  logic [WW-1:0]   weight,
    output logic            post_spike,
    output logic [VW-1:0]   membrane,
    output logic            refractory,
    output logic [CW-1:0]   spike_count
);

    neuron_state_e state_q, state_d;
    logic [VW-1:0] membrane_q, membrane_d;
    logic          post_spike_q, post_spike_d;
    logic [CW-1:0] spike_count_q, spike_count_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    logic [IW-1:0] current;
    logic [VW-1:0] leak;
    logic [VW:0]   v_next;
    logic [VW-1:0] v_sat;

    snn_input_sum u_input_sum (
        .pre_spike_i (pre_spike),
        .weight_i    (weight),
        .current_c   (current)
    );

    // Leak, integrate and saturate; leak <= V so the 13-bit sum never underflows.
    always_comb begin
        leak   = membrane_q >> LEAK_SHIFT;
        v_next = {1'b0, membrane_q} - {1'b0, leak} + (VW+1)'(current);
        v_sat  = (v_next > (VW+1)'(VMAX)) ? VW'(VMAX) : v_next[VW-1:0];
    end

    // Next-state and register-input logic for the neuron FSM.
    always_comb begin
        state_d       = state_q;
        membrane_d    = membrane_q;
        post_spike_d  = 1'b0;
        spike_count_d = spike_count_q;
        rcnt_d        = rcnt_q;

        unique case (state_q)
            INTEGRATE: begin
                if (v_sat >= VW'(THRESHOLD)) begin
                    post_spike_d  = 1'b1;
                    membrane_d    = '0;
                    spike_count_d = spike_count_q + CW'(1);
                    if (REFRACT_CYCLES > 0) begin
                        state_d = REFRACT;
                        rcnt_d  = RW'(REFRACT_CYCLES);
                    end
                end else begin
                    membrane_d = v_sat;
                end
            end
            REFRACT: begin
                membrane_d = '0;
                rcnt_d     = rcnt_q - RW'(1);
                if (rcnt_q == RW'(1)) begin
                    state_d = INTEGRATE;
                end
            end
            default: begin
                state_d = INTEGRATE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INTEGRATE;
            membrane_q    <= '0;
            post_spike_q  <= 1'b0;
            spike_count_q <= '0;
            rcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            membrane_q    <= membrane_d;
            post_spike_q  <= post_spike_d;
            spike_count_q <= spike_count_d;
            rcnt_q        <= rcnt_d;
        end
    end

    assign post_spike  = post_spike_q;
    assign membrane    = membrane_q;
    assign refractory  = (state_q == REFRACT);
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron: default, saturating and zero-refractory variants.
module tb_lif_neuron;

    logic       clk;
    logic       rst_n;

    logic [4:0] pre_a, pre_b, pre_c;
    logic [7:0] w_a, w_b, w_c;

    logic        post_a, post_b, post_c;
    logic [11:0] mem_a, mem_b, mem_c;
    logic        refr_a, refr_b, refr_c;
    logic [7:0]  cnt_a, cnt_b, cnt_c;

    int checks_total;
    int checks_passed;
    int spikes_seen;

    lif_neuron u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_a),
        .weight      (w_a),
        .post_spike  (post_a),
        .membrane    (mem_a),
        .refractory  (refr_a),
        .spike_count (cnt_a)
    );

    lif_neuron #(.THRESHOLD(4095)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_b),
        .weight      (w_b),
        .post_spike  (post_b),
        .membrane    (mem_b),
        .refractory  (refr_b),
        .spike_count (cnt_b)
    );

    lif_neuron #(.REFRACT_CYCLES(0)) u_dut_c (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_c),
        .weight      (w_c),
        .post_spike  (post_c),
        .membrane    (mem_c),
        .refractory  (refr_c),
        .spike_count (cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int p, input int m, input int r, input int c);
        check({tag, ".post"}, 32'(post_a), 32'(p));
        check({tag, ".mem"},  32'(mem_a),  32'(m));
        check({tag, ".refr"}, 32'(refr_a), 32'(r));
        check({tag, ".cnt"},  32'(cnt_a),  32'(c));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        pre_a = '0; w_a = '0;
        pre_b = '0; w_b = '0;
        pre_c = '0; w_c = '0;

        #1;
        check_a("reset_a", 0, 0, 0, 0);
        check("reset_b.mem", 32'(mem_b), 32'd0);
        check("reset_c.cnt", 32'(cnt_c), 32'd0);

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        pre_a = 5'b11111; w_a = 8'd100;
        pre_b = 5'b11111; w_b = 8'd255;

        // Steady drive on A, saturation on B in parallel.
        step(); check_a("steady_e1", 0, 500, 0, 0);
        check("sat_e1.mem", 32'(mem_b), 32'd1275);
        step(); check_a("steady_e2", 0, 938, 0, 0);
        check("sat_e2.mem", 32'(mem_b), 32'd2391);
        step(); check_a("steady_fire1", 1, 0, 1, 1);
        check("sat_e3.mem", 32'(mem_b), 32'd3368);
        step(); check_a("refract_e1", 0, 0, 1, 1);
        check("sat_fire.post", 32'(post_b), 32'd1);
        check("sat_fire.mem",  32'(mem_b),  32'd0);
        check("sat_fire.cnt",  32'(cnt_b),  32'd1);
        pre_b = '0;
        w_a = 8'd255;  // ignored while refractory
        step(); check_a("refract_e2", 0, 0, 1, 1);
        step(); check_a("refract_e3", 0, 0, 1, 1);
        w_a = 8'd100;
        step(); check_a("refract_end", 0, 0, 0, 1);
        step(); check_a("resume_e1", 0, 500, 0, 1);
        step(); check_a("resume_e2", 0, 938, 0, 1);
        step(); check_a("steady_fire2", 1, 0, 1, 2);

        // Recover, reach 938, then let it leak.
        repeat (4) step();
        check("refract2_end.refr", 32'(refr_a), 32'd0);
        step(); check("lk_pre1.mem", 32'(mem_a), 32'd500);
        step(); check("lk_pre2.mem", 32'(mem_a), 32'd938);
        pre_a = '0;
        step(); check("leak_e1.mem", 32'(mem_a), 32'd821);
        step(); check("leak_e2.mem", 32'(mem_a), 32'd719);
        step(); check("leak_e3.mem", 32'(mem_a), 32'd630);
        spikes_seen = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (post_a) spikes_seen++;
        end
        check("leak_nospike", 32'(spikes_seen), 32'd0);
        check("leak_floor.mem", 32'(mem_a), 32'd7);
        check("leak_floor.cnt", 32'(cnt_a), 32'd2);

        // Fire from residual 7, then reset asynchronously mid-refractory.
        pre_a = 5'b11111;
        step(); check("from7_e1.mem", 32'(mem_a), 32'd507);
        step(); check("from7_e2.mem", 32'(mem_a), 32'd944);
        step(); check_a("from7_fire", 1, 0, 1, 3);
        step(); check_a("pre_reset", 0, 0, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_reset", 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        step(); check_a("post_reset_e1", 0, 500, 0, 0);
        step(); check_a("post_reset_e2", 0, 938, 0, 0);
        step(); check_a("post_reset_fire", 1, 0, 1, 1);

        // Zero refractory: fire every cycle, counter wraps.
        pre_c = 5'b11111; w_c = 8'd255;
        step();
        check("r0_e1.post", 32'(post_c), 32'd1);
        check("r0_e1.refr", 32'(refr_c), 32'd0);
        check("r0_e1.cnt",  32'(cnt_c),  32'd1);
        step();
        check("r0_e2.post", 32'(post_c), 32'd1);
        check("r0_e2.mem",  32'(mem_c),  32'd0);
        check("r0_e2.cnt",  32'(cnt_c),  32'd2);
        repeat (253) step();
        check("r0_255.cnt",  32'(cnt_c),  32'd255);
        check("r0_255.refr", 32'(refr_c), 32'd0);
        step();
        check("r0_wrap.cnt",  32'(cnt_c),  32'd0);
        check("r0_wrap.post", 32'(post_c), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that produces the post-synaptic spike consumed by the STDP learning block. Each cycle it sums five pre-synaptic spike lines scaled by the current synaptic weight into a 12-bit membrane potential, applies a shift-based leak, and fires when the potential reaches a threshold. After each spike it enters a fixed refractory period. It closes the loop: STDP weight output drives this block, and this block's `post_spike` drives STDP.

## Interface
- `THRESHOLD`, default 12'd1000: firing threshold. Legal range is 1..4095.
- `LEAK_SHIFT`, default 3: leak per cycle is V >> LEAK_SHIFT. Legal range is 1..11.
- `REFRACT_CYCLES`, default 4: refractory length in cycles. Legal range is 0..255.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `pre_spike`  in  5  pre-synaptic spike lines, sampled every cycle.
- `weight`  in  8  unsigned synaptic weight, shared by all five lines.
- `post_spike`  out  1  registered spike pulse, one cycle wide.
- `membrane`  out  12  registered membrane potential V.
- `refractory`  out  1  high while the neuron is in state REFRACT.
- `spike_count`  out  8  count of emitted spikes; wraps modulo 256.

## Operation
- States:
  - INTEGRATE, the reset state.
  - REFRACT.
- Input current: I = popcount(pre_spike) * weight. I is 11 bits unsigned, maximum 5*255 = 1275.
- INTEGRATE, every edge:
  - leak = V >> LEAK_SHIFT.
  - Vn = V - leak + I, computed at 13 bits. It never underflows because leak <= V.
  - Vs = min(Vn, 4095), i.e. saturate.
  - If Vs >= THRESHOLD:
    - `post_spike` <= 1, V <= 0, `spike_count` += 1.
    - If REFRACT_CYCLES > 0: state <= REFRACT, rcnt <= REFRACT_CYCLES.
    - If REFRACT_CYCLES == 0: stay in INTEGRATE.
  - Otherwise: V <= Vs, `post_spike` <= 0.
- REFRACT, every edge:
  - `pre_spike` and `weight` are ignored.
  - V is held at 0 and `post_spike` <= 0.
  - rcnt decrements.
  - When rcnt == 1 at the edge, state <= INTEGRATE.
- Leak floor: when V < 2^LEAK_SHIFT, leak is 0, so V holds its residual value (for example 7 with LEAK_SHIFT = 3). This is required behaviour.
- `spike_count` wraps 255 -> 0 with no flag.
- A `weight` change takes effect on the same edge it is sampled.

## Timing
- Reset (asynchronous assert):
  - Outputs: `post_spike` = 0, `membrane` = 0, `refractory` = 0, `spike_count` = 0.
  - Internal: state = INTEGRATE, rcnt = 0.
  - These values hold immediately, regardless of the clock.
- Reset deassertion: the first functional edge is the first rising edge with `rst_n` high.
- Latency: inputs sampled at edge k affect `membrane` and `post_spike` after edge k.
- `post_spike` is high for exactly one cycle per fire. It is never high in two consecutive cycles unless REFRACT_CYCLES = 0 and the input still crosses threshold from V = 0.
- `refractory` goes high on the fire edge and stays high for exactly REFRACT_CYCLES cycles.
- Steady firing period = (integrate edges to threshold) + REFRACT_CYCLES.
- Reset mid-REFRACT: the refractory period is aborted and the neuron returns to INTEGRATE with V = 0.

## Structure
- Shared package `snn_pkg`:
  - `VW` = 12, the membrane width.
  - `IW` = 11, the input current width.
  - `VMAX` = 4095.
  - The state enum {INTEGRATE, REFRACT}.
- One sub-module, `snn_input_sum`: a combinational popcount of `pre_spike` times `weight`, producing I. It is reusable by future multi-neuron layers.
- The top level holds the FSM, the membrane register, the refractory counter and the spike counter.

## Test plan
All scenarios use the default parameters unless stated.

- Steady drive: `weight` = 100, `pre_spike` = 5'b11111 held.
  - V sequence is 500, 938, then Vs = 1321 fires.
  - `post_spike` pulses, V = 0, `refractory` is high for 4 cycles.
  - The cycle repeats with a period of 7 cycles.
- Leak only: drive to V = 938, then `pre_spike` = 0.
  - V sequence is 821, 719, 630, ...
  - V settles at 7 and stays there; no spike occurs.
- Saturation: THRESHOLD = 4095, `weight` = 255, all lines active.
  - V sequence is 1275, 2391, 3368, then Vn = 4222 saturates to 4095 and fires.
- Refractory ignore, with REFRACT_CYCLES = 4:
  - Inputs driven during the 4 REFRACT cycles leave `membrane` = 0.
  - Integration resumes on the 5th edge after the fire.
- REFRACT_CYCLES = 0 with I >= THRESHOLD held:
  - `post_spike` is high every cycle and `refractory` stays 0.
  - `spike_count` wraps 255 -> 0 after 256 spikes.
- Asynchronous reset mid-REFRACT, `rst_n` pulsed low between edges:
  - All outputs read 0 immediately.
  - After release, firing restarts from V = 0.
